// File: rtl/matrix_result_drain.sv
// Snapshots the matrix_mult result array LAT cycles after each operand launch and streams it row-major over valid/ready.
// Optional running checksum output enabled by defining MATRIX_DRAIN_CHECKSUM_EN.
module matrix_result_drain #(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int LAT   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [2*WIDTH-1:0]     C [N][N],
    output logic                   busy,
    output logic [2*WIDTH-1:0]     out_data,
    output logic [$clog2(N)-1:0]   out_row,
    output logic [$clog2(N)-1:0]   out_col,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
`ifdef MATRIX_DRAIN_CHECKSUM_EN
    ,
    output logic [2*WIDTH-1:0]     checksum
`endif
);

    localparam int IW = $clog2(N);
    localparam int DW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STREAM
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [IW-1:0]   row_q, row_d;
    logic [IW-1:0]   col_q, col_d;
    logic [DW-1:0]   snap_q [N][N];
    logic [DW-1:0]   snap_d [N][N];
    logic            at_last;
    logic            handshake;

`ifdef MATRIX_DRAIN_CHECKSUM_EN
    logic [DW-1:0]   sum_q, sum_d;
`endif

    assign at_last   = (row_q == IW'(N - 1)) && (col_q == IW'(N - 1));
    assign handshake = (state_q == S_STREAM) && out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        snap_d  = snap_q;
`ifdef MATRIX_DRAIN_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = 8'(LAT - 1);
                    state_d = S_WAIT;
`ifdef MATRIX_DRAIN_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                // C is only trusted on the edge where the counter runs out
                if (cnt_q == 8'd0) begin
                    snap_d  = C;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_STREAM;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_STREAM: begin
                if (handshake) begin
`ifdef MATRIX_DRAIN_CHECKSUM_EN
                    sum_d = sum_q + snap_q[row_q][col_q];
`endif
                    if (at_last) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = S_IDLE;
                    end else if (col_q == IW'(N - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    snap_q[i][j] <= '0;
                end
            end
`ifdef MATRIX_DRAIN_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            snap_q  <= snap_d;
`ifdef MATRIX_DRAIN_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // All outputs decode registered state only, so out_ready never reaches them combinationally
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_STREAM);
    assign out_last  = out_valid && at_last;
    assign out_data  = out_valid ? snap_q[row_q][col_q] : '0;
    assign out_row   = row_q;
    assign out_col   = col_q;

`ifdef MATRIX_DRAIN_CHECKSUM_EN
    assign checksum  = sum_q;
`endif

endmodule

// File: tb/tb_matrix_result_drain.sv
// Self-checking bench for matrix_result_drain: directed scenarios with random matrices and random backpressure.
module tb_matrix_result_drain;

   localparam int N     = 4;
   localparam int WIDTH = 16;
   localparam int LAT   = 3;
   localparam int DW    = 2 * WIDTH;
   localparam int NN    = N * N;

   logic           clock;
   logic           rstN;
   logic           start;
   logic [DW-1:0]  cDrive [N][N];
   logic           busy;
   logic [DW-1:0]  outData;
   logic [1:0]     outRow;
   logic [1:0]     outCol;
   logic           outValid;
   logic           outReady;
   logic           outLast;
`ifdef MATRIX_DRAIN_CHECKSUM_EN
   logic [DW-1:0]  checksum;
`endif

   int testsRun  = 0;
   int testsFail = 0;

   matrix_result_drain #(.N(N), .WIDTH(WIDTH), .LAT(LAT)) dut (
      .clk       (clock),
      .rst_n     (rstN),
      .start     (start),
      .C         (cDrive),
      .busy      (busy),
      .out_data  (outData),
      .out_row   (outRow),
      .out_col   (outCol),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_last  (outLast)
`ifdef MATRIX_DRAIN_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   // Free-running clock, 10 time units per period
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts, and reports any mismatch with tag and values
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle just past the rising edge
   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   // Fill the driven C matrix: mode 0 gives C[i][j]=i+j, mode 1 gives random values
   task automatic loadMatrix(input int mode);
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            cDrive[i][j] = (mode == 0) ? DW'(i + j) : DW'($urandom);
         end
      end
   endtask

   // One launch-and-drain transaction checked against a row-major model of the matrix held in C at launch.
   // readyMode: 0 always ready, 1 random ready, 2 stall the first 5 valid cycles then ready.
   task automatic applyStimulus(input int readyMode, input bit pokeStart, input int resetAfter, input bit isolate);
      logic [DW-1:0] expected [NN];
      logic [DW-1:0] expectedSum;
      int            k;
      int            guard;
      int            waited;
      logic          rdy;

      expectedSum = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            expected[i * N + j] = cDrive[i][j];
            expectedSum         = expectedSum + cDrive[i][j];
         end
      end

      start    = 1'b1;
      outReady = (readyMode == 0);
      stepCycle();
      start    = 1'b0;
      waited   = 1;
      checkOutput("busy_after_start", busy, 1);
      checkOutput("valid_in_wait", outValid, 0);
`ifdef MATRIX_DRAIN_CHECKSUM_EN
      checkOutput("checksum_cleared", checksum, 0);
`endif

      while (!outValid && waited < 20) begin
         start = pokeStart && (waited == 2);
         stepCycle();
         waited++;
      end
      start = 1'b0;
      checkOutput("first_valid_latency", waited, LAT + 1);

      if (isolate) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               cDrive[i][j] = '1;
            end
         end
      end

      k     = 0;
      guard = 0;
      while (k < NN && guard < 300) begin
         checkOutput("stream_valid", outValid, 1);
         checkOutput("stream_busy", busy, 1);
         checkOutput("stream_data", outData, expected[k]);
         checkOutput("stream_row", outRow, k / N);
         checkOutput("stream_col", outCol, k % N);
         checkOutput("stream_last", outLast, (k == NN - 1));
         case (readyMode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = (guard >= 5);
         endcase
         outReady = rdy;
         start    = pokeStart && ((k == 8) || (k == NN - 1 && rdy));
         if (rdy) k++;
         stepCycle();
         guard++;
         start = 1'b0;
         if (resetAfter != 0 && k == resetAfter) begin
            rstN = 1'b0;
            #1;
            checkOutput("reset_valid_drop", outValid, 0);
            checkOutput("reset_busy_drop", busy, 0);
            checkOutput("reset_last_drop", outLast, 0);
`ifdef MATRIX_DRAIN_CHECKSUM_EN
            checkOutput("reset_checksum", checksum, 0);
`endif
            stepCycle();
            rstN     = 1'b1;
            outReady = 1'b0;
            stepCycle();
            checkOutput("post_reset_idle", outValid, 0);
            return;
         end
      end
      outReady = 1'b0;
      checkOutput("stream_complete", k, NN);
      checkOutput("busy_falls", busy, 0);
      checkOutput("valid_falls", outValid, 0);
`ifdef MATRIX_DRAIN_CHECKSUM_EN
      checkOutput("checksum_final", checksum, expectedSum);
`endif

      if (pokeStart) begin
         for (int c = 0; c < LAT + 4; c++) begin
            stepCycle();
            checkOutput("no_second_stream_valid", outValid, 0);
            checkOutput("no_second_stream_busy", busy, 0);
         end
`ifdef MATRIX_DRAIN_CHECKSUM_EN
         checkOutput("checksum_holds", checksum, expectedSum);
`endif
      end
   endtask

   // Directed sequence of scenarios
   initial begin
      rstN     = 1'b0;
      start    = 1'b0;
      outReady = 1'b0;
      loadMatrix(0);
      #1;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_valid", outValid, 0);
      checkOutput("reset_last", outLast, 0);
      checkOutput("reset_data", outData, 0);
      checkOutput("reset_row", outRow, 0);
      checkOutput("reset_col", outCol, 0);
`ifdef MATRIX_DRAIN_CHECKSUM_EN
      checkOutput("reset_checksum_init", checksum, 0);
`endif
      stepCycle();
      stepCycle();
      rstN = 1'b1;
      stepCycle();

      $display("[TB] basic stream with snapshot isolation");
      loadMatrix(0);
      applyStimulus(0, 1'b0, 0, 1'b1);

      $display("[TB] backpressure");
      loadMatrix(0);
      applyStimulus(2, 1'b0, 0, 1'b0);

      $display("[TB] start while busy");
      loadMatrix(1);
      applyStimulus(0, 1'b1, 0, 1'b0);

      $display("[TB] reset mid-stream");
      loadMatrix(1);
      applyStimulus(0, 1'b0, 7, 1'b0);
      loadMatrix(1);
      applyStimulus(0, 1'b0, 0, 1'b0);

      $display("[TB] random matrices with random backpressure");
      for (int r = 0; r < 4; r++) begin
         loadMatrix(1);
         applyStimulus(1, 1'(r % 2), 0, 1'(r == 1));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule
